// File: rtl/ws2812_serializer.sv
// ws2812_serializer: fetches pixel words over req/done and drives a WS2812 NRZ data line, double-buffered
module ws2812_serializer #(
  parameter int N_LEDS    = 64,
  parameter int W_ADDR    = 6,
  parameter int W_DATA    = 24,
  parameter int T0H_CYC   = 40,
  parameter int T1H_CYC   = 80,
  parameter int BIT_CYC   = 125,
  parameter int RESET_CYC = 6000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  output logic              pix_req,
  output logic [W_ADDR-1:0] pix_addr,
  input  logic [W_DATA-1:0] pix_data,
  input  logic              pix_done,
  output logic              dout,
  output logic              busy,
  output logic              frame_done,
  output logic              underrun
);
  localparam int W_CYC = $clog2(BIT_CYC + 1);
  localparam int W_LAT = $clog2(RESET_CYC + 1);
  localparam int W_BIT = $clog2(W_DATA + 1);
  localparam logic [W_CYC-1:0]  CYC_LAST  = W_CYC'(BIT_CYC - 1);
  localparam logic [W_CYC-1:0]  T0H       = W_CYC'(T0H_CYC);
  localparam logic [W_CYC-1:0]  T1H       = W_CYC'(T1H_CYC);
  localparam logic [W_LAT-1:0]  LAT_LAST  = W_LAT'(RESET_CYC - 1);
  localparam logic [W_BIT-1:0]  BIT_TOP   = W_BIT'(W_DATA - 1);
  localparam logic [W_ADDR-1:0] ADDR_LAST = W_ADDR'(N_LEDS - 1);

  typedef enum logic [2:0] {IDLE, FETCH0, SHIFT, STALL, LATCH} state_t;

  state_t            state_q, state_d;
  logic [W_DATA-1:0] shreg_q, shreg_d, nbuf_q, nbuf_d;
  logic              nvalid_q, nvalid_d, req_q, req_d, und_q, und_d;
  logic [W_ADDR-1:0] addr_q, addr_d, cur_q, cur_d;
  logic [W_BIT-1:0]  bit_q, bit_d;
  logic [W_CYC-1:0]  cyc_q, cyc_d;
  logic [W_LAT-1:0]  lat_q, lat_d;
  logic              take, in_shift, bit_end, pix_end, last_pix, lat_end, load, more, start;

  assign take     = req_q & pix_done;
  assign in_shift = state_q == SHIFT;
  assign bit_end  = in_shift && cyc_q == CYC_LAST;
  assign pix_end  = bit_end && bit_q == '0;
  assign last_pix = cur_q == ADDR_LAST;
  assign lat_end  = state_q == LATCH && lat_q == LAT_LAST;
  assign more     = addr_q != ADDR_LAST;
  // The buffered word goes straight into the shifter; the request for the following pixel starts on the same edge.
  assign load     = nvalid_q && (state_q == FETCH0 || state_q == STALL || (pix_end && !last_pix));
  assign start    = ((state_q == IDLE || lat_end) && enable) || (load && more);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      shreg_q  <= '0;
      nbuf_q   <= '0;
      nvalid_q <= 1'b0;
      req_q    <= 1'b0;
      und_q    <= 1'b0;
      addr_q   <= '0;
      cur_q    <= '0;
      bit_q    <= '0;
      cyc_q    <= '0;
      lat_q    <= '0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      nbuf_q   <= nbuf_d;
      nvalid_q <= nvalid_d;
      req_q    <= req_d;
      und_q    <= und_d;
      addr_q   <= addr_d;
      cur_q    <= cur_d;
      bit_q    <= bit_d;
      cyc_q    <= cyc_d;
      lat_q    <= lat_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (enable) state_d = FETCH0;
      FETCH0:  if (nvalid_q) state_d = SHIFT;
      SHIFT:   if (pix_end) state_d = last_pix ? LATCH : (nvalid_q ? SHIFT : STALL);
      STALL:   if (nvalid_q) state_d = SHIFT;
      LATCH:   if (lat_end) state_d = enable ? FETCH0 : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    nbuf_d   = take ? pix_data : nbuf_q;
    nvalid_d = load ? 1'b0 : (take | nvalid_q);
    shreg_d  = load ? nbuf_q : (bit_end ? shreg_q << 1 : shreg_q);
    bit_d    = load ? BIT_TOP : (bit_end ? bit_q - 1'b1 : bit_q);
    cyc_d    = (in_shift && !bit_end) ? cyc_q + 1'b1 : '0;
    cur_d    = load ? addr_q : cur_q;
    req_d    = start | (req_q & ~pix_done);
    addr_d   = lat_end ? '0 : ((load && more) ? addr_q + 1'b1 : addr_q);
    lat_d    = (state_q == LATCH && !lat_end) ? lat_q + 1'b1 : '0;
    und_d    = und_q | (state_q == STALL);
  end

  always_comb begin
    dout       = in_shift && cyc_q < (shreg_q[W_DATA-1] ? T1H : T0H);
    busy       = state_q != IDLE;
    frame_done = lat_end;
    pix_req    = req_q;
    pix_addr   = addr_q;
    underrun   = und_q;
  end
endmodule

// File: tb/tb_ws2812_serializer.sv
// tb_ws2812_serializer: random-word colour source, scoreboard of delivered words vs waveform decoded from dout
module tb_ws2812_serializer;
  localparam int N = 2, WA = 6, WD = 24, T0H = 2, T1H = 4, BITC = 6, RSTC = 10;

  logic          clk = 1'b0, rst = 1'b1, enable = 1'b0, pix_done = 1'b0;
  logic [WD-1:0] pix_data = '0;
  logic          pix_req, dout, busy, frame_done, underrun;
  logic [WA-1:0] pix_addr;

  int            checks = 0, failures = 0, frames = 0;
  logic [WD-1:0] exp_q[$];
  logic [WD-1:0] mem[N];
  logic          fix_words = 1'b1;
  int            slow_addr = -1, inj_n = 0;

  ws2812_serializer #(.N_LEDS(N), .W_ADDR(WA), .W_DATA(WD), .T0H_CYC(T0H), .T1H_CYC(T1H),
                      .BIT_CYC(BITC), .RESET_CYC(RSTC)) dut (
    .clk(clk), .rst(rst), .enable(enable), .pix_req(pix_req), .pix_addr(pix_addr),
    .pix_data(pix_data), .pix_done(pix_done), .dout(dout), .busy(busy),
    .frame_done(frame_done), .underrun(underrun));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Colour source: answers each req rise after a delay; every word it hands over is what dout must carry.
  int            s_cnt = 0, s_inj = 0;
  logic          s_prev = 1'b0;
  logic [WA-1:0] s_addr;
  logic [WD-1:0] s_word;
  initial forever begin
    @(negedge clk); #1;
    pix_done = 1'b0;
    if (rst) s_cnt = 0;
    else if (s_inj != inj_n) begin
      s_inj = inj_n;
      pix_done = 1'b1;
      pix_data = WD'($urandom);
    end else if (s_cnt > 0) begin
      s_cnt--;
      if (s_cnt == 0) begin
        s_word = fix_words ? mem[s_addr] : WD'($urandom);
        pix_data = s_word;
        pix_done = 1'b1;
        exp_q.push_back(s_word);
      end
    end else if (pix_req && !s_prev) begin
      s_addr = pix_addr;
      s_cnt = (int'(s_addr) == slow_addr) ? 200 : int'($urandom_range(1, 6));
    end
    s_prev = pix_req;
  end

  // Monitor: decodes high widths into bits, checks timing and the fetch protocol.
  int            m_hi = 0, m_since = 0, m_bits = 0, m_words = 0, m_exp_addr = 0;
  logic          m_pdout = 1'b0, m_preq = 1'b0;
  logic [WA-1:0] m_req_addr = '0;
  logic [WD-1:0] m_word = '0;
  initial forever begin
    @(posedge clk); #1;
    if (rst) begin
      exp_q.delete();
      m_hi = 0; m_since = 0; m_bits = 0; m_words = 0; m_exp_addr = 0;
      m_pdout = 1'b0; m_preq = 1'b0;
      continue;
    end
    if (m_preq && pix_done) chk("req_drop", pix_req, 0);
    if (pix_req && !m_preq) begin
      chk("req_addr", pix_addr, m_exp_addr);
      m_req_addr = pix_addr;
      m_exp_addr++;
    end else if (pix_req) chk("addr_hold", pix_addr, m_req_addr);
    if (dout && !m_pdout) begin
      if (m_bits != 0) chk("bit_period", m_since, BITC);
      else if (m_words != 0) chk("word_gap", m_since >= BITC, 1);
      m_since = 0;
      m_hi = 0;
    end
    if (dout) m_hi++;
    if (!dout && m_pdout) begin
      chk("high_width", m_hi, (m_hi >= T1H) ? T1H : T0H);
      m_word = {m_word[WD-2:0], m_hi >= T1H};
      m_bits++;
      if (m_bits == WD) begin
        m_bits = 0;
        m_words++;
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL word_extra actual=%06h required=none", m_word);
        end else chk("word", m_word, exp_q.pop_front());
      end
    end
    m_since++;
    if (frame_done) begin
      chk("latch_time", m_since, BITC + RSTC);
      chk("frame_words", m_words, N);
      m_words = 0;
      m_exp_addr = 0;
      frames++;
    end
    m_pdout = dout;
    m_preq = pix_req;
  end

  task automatic wait_frames(input int target);
    int n = 0;
    while (frames < target && n < 4000) begin
      @(posedge clk); #2;
      n++;
    end
    checks++;
    if (frames < target) begin
      failures++;
      $display("FAIL frame_wait frames=%0d required=%0d", frames, target);
    end
  endtask

  task automatic wait_dout_high();
    int n = 0;
    while (!dout && n < 2000) begin
      @(posedge clk); #2;
      n++;
    end
    chk("dout_seen", dout, 1);
  endtask

  initial begin
    mem[0] = 24'hA50000;
    mem[1] = 24'h000001;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_dout", dout, 0);
    chk("rst_req", pix_req, 0);
    chk("rst_addr", pix_addr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_underrun", underrun, 0);
    @(negedge clk);
    rst = 1'b0;
    enable = 1'b1;
    wait_frames(1);
    fix_words = 1'b0;
    wait_frames(3);
    chk("no_underrun", underrun, 0);
    slow_addr = 1;
    wait_frames(frames + 2);
    chk("underrun_set", underrun, 1);
    slow_addr = -1;
    wait_frames(frames + 1);
    chk("underrun_sticky", underrun, 1);
    wait_dout_high();
    @(negedge clk);
    enable = 1'b0;
    wait_frames(frames + 1);
    repeat (3) @(posedge clk);
    #2;
    chk("stop_busy", busy, 0);
    chk("stop_req", pix_req, 0);
    @(negedge clk);
    inj_n++;
    repeat (6) @(posedge clk);
    #2;
    chk("spurious_busy", busy, 0);
    chk("spurious_req", pix_req, 0);
    chk("spurious_frames", frames, 7);
    @(negedge clk);
    enable = 1'b1;
    wait_frames(frames + 1);
    wait_dout_high();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #2;
    chk("midrst_dout", dout, 0);
    chk("midrst_req", pix_req, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_underrun", underrun, 0);
    @(negedge clk);
    rst = 1'b0;
    inj_n++;
    wait_frames(frames + 2);
    chk("end_underrun", underrun, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end
endmodule
